// File: rtl/datapath_reg_alu_mc.sv
// Multi-cycle register-file / ALU / RAM datapath. Loads stall the control unit
// through the cw_valid/cw_ready handshake for MEM_LAT cycles.
module datapath_reg_alu_mc #(
   parameter  int WIDTH     = 64,
   parameter  int REGS      = 32,
   parameter  int MEM_DEPTH = 256,
   parameter  int MEM_LAT   = 2,
   localparam int RA        = $clog2(REGS),
   localparam int MA        = $clog2(MEM_DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cw_valid,
   output logic             cw_ready,
   input  logic [RA-1:0]    da,
   input  logic [RA-1:0]    sa,
   input  logic [RA-1:0]    sb,
   input  logic [3:0]       fs,
   input  logic             sel_b,
   input  logic             reg_w,
   input  logic             mem_w,
   input  logic             mem_rd,
   input  logic [1:0]       wb_sel,
   input  logic             pc_sel,
   input  logic             sl,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] pc4,
   output logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] pc_in,
   output logic [4:0]       status_out,
   output logic             retire
);

   localparam int SW = $clog2(WIDTH);
   localparam int CW = $clog2(MEM_LAT + 1);
   localparam logic [RA-1:0] ZERO_REG = RA'(REGS - 1);
   localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT);

   typedef enum logic [0:0] {
      ST_IDLE      = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } state_t;

   logic [WIDTH-1:0] r_regs [REGS];
   logic [WIDTH-1:0] r_mem  [MEM_DEPTH];
   logic [WIDTH-1:0] r_pipe [MEM_LAT];
   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [RA-1:0]    r_ld_da;
   logic             r_ld_w;
   logic [MA-1:0]    r_ld_addr;
   logic [3:0]       r_flags;
   logic             r_retire;

   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_rdb;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_dif;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic             w_z;
   logic [MA-1:0]    w_addr;
   logic [MA-1:0]    w_rd_addr;
   logic [WIDTH-1:0] w_data;
   logic             w_accept;
   logic             w_ld_done;

   // The top register index (and anything above it) always reads as zero.
   assign w_a       = (sa >= ZERO_REG) ? {WIDTH{1'b0}} : r_regs[sa];
   assign w_rdb     = (sb >= ZERO_REG) ? {WIDTH{1'b0}} : r_regs[sb];
   assign w_b       = sel_b ? k : w_rdb;
   assign w_z       = (w_res == {WIDTH{1'b0}});
   assign w_addr    = w_res[MA-1:0];
   assign w_rd_addr = (r_state == ST_IDLE) ? w_addr : r_ld_addr;
   assign w_accept  = cw_valid && (r_state == ST_IDLE);
   assign w_ld_done = (r_state == ST_LOAD_WAIT) && (r_cnt == CW'(1));

   // ALU result and carry/overflow for the current control fields.
   always_comb begin
      w_sum = {1'b0, w_a} + {1'b0, w_b};
      w_dif = {1'b0, w_a} - {1'b0, w_b};
      w_res = {WIDTH{1'b0}};
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (fs)
         4'b0000: w_res = w_a & w_b;
         4'b0001: w_res = w_a | w_b;
         4'b0010: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
         end
         4'b0011: begin
            w_res = w_dif[WIDTH-1:0];
            w_c   = ~w_dif[WIDTH];
            w_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_dif[WIDTH-1] != w_a[WIDTH-1]);
         end
         4'b0100: w_res = w_a ^ w_b;
         4'b0101: w_res = w_a << w_b[SW-1:0];
         4'b0110: w_res = w_a >> w_b[SW-1:0];
         4'b0111: w_res = w_b;
         default: w_res = {WIDTH{1'b0}};
      endcase
   end

   // Writeback bus; the RAM source is the live array in IDLE, the delay line otherwise.
   always_comb begin
      w_data = {WIDTH{1'b0}};
      case (wb_sel)
         2'b00: w_data = w_res;
         2'b01: begin
            if (r_state == ST_IDLE) begin
               w_data = r_mem[w_addr];
            end else begin
               w_data = r_pipe[MEM_LAT-1];
            end
         end
         2'b10:   w_data = w_rdb;
         2'b11:   w_data = pc4;
         default: w_data = {WIDTH{1'b0}};
      endcase
   end

   // Control FSM: accept, load wait counter, flag latch and retire pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= {CW{1'b0}};
         r_ld_da   <= {RA{1'b0}};
         r_ld_w    <= 1'b0;
         r_ld_addr <= {MA{1'b0}};
         r_flags   <= 4'b0000;
         r_retire  <= 1'b0;
      end else begin
         r_retire <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (sl) begin
                     r_flags <= {w_v, w_c, w_z, w_res[WIDTH-1]};
                  end
                  if (mem_rd) begin
                     r_state   <= ST_LOAD_WAIT;
                     r_cnt     <= LAT_INIT;
                     r_ld_da   <= da;
                     r_ld_w    <= reg_w;
                     r_ld_addr <= w_addr;
                  end else begin
                     r_retire <= 1'b1;
                  end
               end
            end
            ST_LOAD_WAIT: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state  <= ST_IDLE;
                  r_retire <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Register file; load completion and ALU writeback never coincide.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REGS; i++) begin
            r_regs[i] <= {WIDTH{1'b0}};
         end
      end else if (w_ld_done && r_ld_w && (r_ld_da < ZERO_REG)) begin
         r_regs[r_ld_da] <= r_pipe[MEM_LAT-1];
      end else if (w_accept && !mem_rd && reg_w && (da < ZERO_REG)) begin
         r_regs[da] <= w_data;
      end
   end

   // RAM store port; a store flagged together with a load is dropped.
   always_ff @(posedge clock) begin
      if (w_accept && mem_w && !mem_rd) begin
         r_mem[w_addr] <= w_rdb;
      end
   end

   // RAM read delay line modelling the MEM_LAT read latency.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            r_pipe[i] <= {WIDTH{1'b0}};
         end
      end else begin
         r_pipe[0] <= r_mem[w_rd_addr];
         for (int i = 1; i < MEM_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign cw_ready   = (r_state == ST_IDLE);
   assign data       = w_data;
   assign pc_in      = pc_sel ? k : w_a;
   assign status_out = {r_flags, w_z};
   assign retire     = r_retire;

endmodule

// File: tb/tb_datapath_reg_alu_mc.sv
// Scoreboard bench for datapath_reg_alu_mc: the driver queues expectations,
// the monitor checks data/status/pc_in at each accepted control word.
module tb_datapath_reg_alu_mc;

   localparam logic [3:0]  F_AND = 4'b0000, F_OR = 4'b0001, F_ADD = 4'b0010, F_SUB = 4'b0011;
   localparam logic [3:0]  F_XOR = 4'b0100, F_SHL = 4'b0101, F_SHR = 4'b0110, F_PASS = 4'b0111;
   localparam logic [63:0] PC4 = 64'h0000_0000_0040_1004;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cw_valid, cw_ready;
   logic [4:0]  da, sa, sb;
   logic [3:0]  fs;
   logic        sel_b, reg_w, mem_w, mem_rd, pc_sel, sl;
   logic [1:0]  wb_sel;
   logic [63:0] k, pc4, data, pc_in;
   logic [4:0]  status_out;
   logic        retire;

   typedef struct {
      logic [2:0]  chk;
      logic [63:0] d;
      logic [4:0]  s;
      logic [63:0] p;
      int          tag;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   int          ret_seen = 0;
   int          ret_exp = 0;
   int          tag_n = 0;
   logic [3:0]  ef;

   datapath_reg_alu_mc #(.WIDTH(64), .REGS(32), .MEM_DEPTH(256), .MEM_LAT(3)) dut (
      .clock(clock), .reset(reset), .cw_valid(cw_valid), .cw_ready(cw_ready),
      .da(da), .sa(sa), .sb(sb), .fs(fs), .sel_b(sel_b), .reg_w(reg_w),
      .mem_w(mem_w), .mem_rd(mem_rd), .wb_sel(wb_sel), .pc_sel(pc_sel), .sl(sl),
      .k(k), .pc4(pc4), .data(data), .pc_in(pc_in), .status_out(status_out),
      .retire(retire)
   );

   always #5 clock = ~clock;

   // Monitor: count retires and check each accepted word against the queue head.
   always @(negedge clock) begin
      exp_t e;
      if (reset && retire) ret_seen++;
      if (reset && cw_valid && cw_ready) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_accept: no queued expectation");
         end else begin
            e = q.pop_front();
            if (e.chk[0]) begin
               total++;
               if (data !== e.d) begin
                  bad++;
                  $display("FAIL data#%0d got=%h exp=%h", e.tag, data, e.d);
               end
            end
            if (e.chk[1]) begin
               total++;
               if (status_out !== e.s) begin
                  bad++;
                  $display("FAIL status#%0d got=%b exp=%b", e.tag, status_out, e.s);
               end
            end
            if (e.chk[2]) begin
               total++;
               if (pc_in !== e.p) begin
                  bad++;
                  $display("FAIL pc_in#%0d got=%h exp=%h", e.tag, pc_in, e.p);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic issue(input logic [4:0] i_da, input logic [4:0] i_sa, input logic [4:0] i_sb,
                        input logic [3:0] i_fs, input logic i_selb, input logic i_regw,
                        input logic i_memw, input logic i_memrd, input logic [1:0] i_wb,
                        input logic i_pcsel, input logic i_sl, input logic [63:0] i_k,
                        input logic [2:0] i_chk, input logic [63:0] i_d, input logic [4:0] i_s,
                        input logic [63:0] i_p);
      exp_t e;
      logic ok;
      ok    = 1'b0;
      e.chk = i_chk; e.d = i_d; e.s = i_s; e.p = i_p; e.tag = tag_n;
      tag_n++;
      q.push_back(e);
      da = i_da; sa = i_sa; sb = i_sb; fs = i_fs; sel_b = i_selb; reg_w = i_regw;
      mem_w = i_memw; mem_rd = i_memrd; wb_sel = i_wb; pc_sel = i_pcsel; sl = i_sl; k = i_k;
      cw_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (cw_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL accept_timeout#%0d got=cw_ready_low exp=accept", e.tag);
         q.delete(q.size() - 1);
      end else begin
         ret_exp++;
      end
      @(posedge clock);
      #1;
      cw_valid = 1'b0;
   endtask

   task automatic setr(input logic [4:0] r, input logic [63:0] v);
      issue(r, 5'd0, 5'd0, F_PASS, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, v,
            3'b001, v, 5'b00000, 64'd0);
   endtask

   task automatic alu(input logic [4:0] a, input logic [3:0] f, input logic [63:0] kv,
                      input logic [63:0] exp);
      issue(5'd0, a, 5'd0, f, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, kv,
            3'b001, exp, 5'b00000, 64'd0);
   endtask

   task automatic rd(input logic [4:0] r, input logic [63:0] exp, input logic [3:0] flags);
      issue(5'd0, 5'd0, r, F_PASS, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 64'd0,
            3'b111, exp, {flags, (exp == 64'd0)}, 64'd0);
   endtask

   initial begin
      int lo;
      int r0;
      cw_valid = 1'b0; da = 5'd0; sa = 5'd0; sb = 5'd0; fs = F_PASS; sel_b = 1'b1;
      reg_w = 1'b0; mem_w = 1'b0; mem_rd = 1'b0; wb_sel = 2'b00; pc_sel = 1'b1;
      sl = 1'b0; k = 64'd1; pc4 = PC4;
      #2 reset = 1'b0;
      #20;
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("rst_ready", {63'd0, cw_ready}, 64'd1);
      chk("rst_retire", {63'd0, retire}, 64'd0);
      chk("rst_status", {59'd0, status_out}, 64'd0);
      @(posedge clock);
      #1;
      ef = 4'b0000;
      for (int i = 0; i < 32; i++) rd(5'(i), 64'd0, ef);

      setr(5'd5, 64'h7FFF_FFFF_FFFF_FFFF);
      setr(5'd1, 64'd3);
      setr(5'd2, 64'd3);
      setr(5'd9, 64'hFFFF_FFFF_FFFF_FFFF);
      setr(5'd3, 64'h0000_0000_0000_DEAD);

      // Signed overflow on ADD, then zero result with no-borrow on SUB.
      issue(5'd6, 5'd5, 5'd0, F_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 64'd1,
            3'b011, 64'h8000_0000_0000_0000, 5'b00000, 64'd0);
      ef = 4'b1001;
      rd(5'd6, 64'h8000_0000_0000_0000, ef);
      issue(5'd7, 5'd1, 5'd2, F_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 64'd0,
            3'b111, 64'd0, {4'b1001, 1'b1}, 64'd3);
      ef = 4'b0110;
      rd(5'd7, 64'd0, ef);
      issue(5'd10, 5'd9, 5'd0, F_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 64'd1,
            3'b011, 64'd0, {4'b0110, 1'b1}, 64'd0);
      issue(5'd12, 5'd1, 5'd0, F_SUB, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 64'd5,
            3'b011, 64'hFFFF_FFFF_FFFF_FFFE, {4'b0110, 1'b0}, 64'd0);
      ef = 4'b0001;
      rd(5'd12, 64'hFFFF_FFFF_FFFF_FFFE, ef);
      issue(5'd13, 5'd6, 5'd0, F_SUB, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 64'd1,
            3'b011, 64'h7FFF_FFFF_FFFF_FFFF, {4'b0001, 1'b0}, 64'd0);
      ef = 4'b1100;
      rd(5'd13, 64'h7FFF_FFFF_FFFF_FFFF, ef);

      alu(5'd1, F_SHL, 64'd4, 64'h30);
      alu(5'd1, F_SHL, 64'd65, 64'd6);
      alu(5'd5, F_SHR, 64'd60, 64'd7);
      alu(5'd5, F_AND, 64'hF0F0, 64'hF0F0);
      alu(5'd1, F_OR, 64'h100, 64'h103);
      alu(5'd1, F_XOR, 64'd1, 64'd2);
      alu(5'd5, 4'b1000, 64'd1, 64'd0);
      alu(5'd5, 4'b1111, 64'd1, 64'd0);
      issue(5'd0, 5'd0, 5'd0, F_PASS, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 64'd9,
            3'b001, PC4, 5'b00000, 64'd0);

      setr(5'd31, 64'h55);
      rd(5'd31, 64'd0, ef);
      setr(5'd14, 64'h77);
      issue(5'd14, 5'd14, 5'd0, F_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 64'd1,
            3'b001, 64'h78, 5'b00000, 64'd0);
      rd(5'd14, 64'h78, ef);

      // Store to address 300 (wraps to 44), then load 44 on the next accept.
      issue(5'd0, 5'd0, 5'd3, F_PASS, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 64'd300,
            3'b001, 64'hDEAD, 5'b00000, 64'd0);
      issue(5'd8, 5'd0, 5'd0, F_PASS, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 64'd44,
            3'b001, 64'hDEAD, 5'b00000, 64'd0);
      lo = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         if (cw_ready) break;
         lo++;
      end
      chk("load_stall_cycles", 64'(lo), 64'd3);
      chk("load_retire", {63'd0, retire}, 64'd1);
      @(posedge clock);
      #1;
      rd(5'd8, 64'hDEAD, ef);

      // Load interrupted by reset in its first wait cycle.
      issue(5'd11, 5'd0, 5'd0, F_PASS, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 64'd44,
            3'b001, 64'hDEAD, 5'b00000, 64'd0);
      ret_exp--;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("midrst_ready", {63'd0, cw_ready}, 64'd1);
      chk("midrst_retire", {63'd0, retire}, 64'd0);
      r0 = ret_seen;
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (6) @(negedge clock);
      chk("midrst_no_retire", 64'(ret_seen), 64'(r0));
      @(posedge clock);
      #1;
      ef = 4'b0000;
      rd(5'd11, 64'd0, ef);
      rd(5'd5, 64'd0, ef);

      for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clock);
      repeat (3) @(negedge clock);
      chk("queue_drained", 64'(q.size()), 64'd0);
      chk("retire_count", 64'(ret_seen), 64'(ret_exp));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
